// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache tag controller: serialises one CPU access at a time through
// tag lookup, hit/miss resolution, refill or write-through, and a full-array flush.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned TAG_W  = 36,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_hit,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              tag_re,
  output logic              tag_we,
  output logic [IDX_W-1:0]  tag_addr,
  output logic [TAG_W:0]    tag_wdata,
  input  logic [TAG_W:0]    tag_rdata,
  output logic              data_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned OFF_W = ADDR_W - IDX_W - TAG_W;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCompare,
    StMem,
    StFill,
    StResp,
    StFlush
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]   tag_q;
  logic [IDX_W-1:0]   idx_q;
  logic               hit_now;

  assign tag_q   = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_q   = addr_q[OFF_W +: IDX_W];
  assign hit_now = tag_rdata[TAG_W] & (tag_rdata[TAG_W-1:0] == tag_q);

  // State register
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      we_q        <= 1'b0;
      hit_q       <= 1'b0;
      flush_cnt_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      hit_q       <= hit_d;
      flush_cnt_q <= flush_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    hit_d       = hit_q;
    flush_cnt_d = flush_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    unique case (state_q)
      StIdle: begin
        // Flush has priority; a coincident CPU request is dropped, not latched.
        if (flush_req) begin
          flush_cnt_d = '0;
          state_d     = StFlush;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          state_d = StLookup;
        end
      end
      StLookup: state_d = StCompare;
      StCompare: begin
        hit_d = hit_now;
        if (hit_now) begin
          if (~&hit_cnt_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
          if (~&miss_cnt_q) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
        state_d = (!we_q && hit_now) ? StResp : StMem;
      end
      StMem: begin
        if (mem_ack) state_d = (we_q && !hit_q) ? StResp : StFill;
      end
      StFill: state_d = StResp;
      StResp: state_d = StIdle;
      StFlush: begin
        flush_cnt_d = flush_cnt_q + IDX_W'(1);
        if (&flush_cnt_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs, derived only from registered state
  always_comb begin
    cpu_ready  = 1'b0;
    cpu_done   = 1'b0;
    cpu_hit    = 1'b0;
    flush_busy = 1'b0;
    tag_re     = 1'b0;
    tag_we     = 1'b0;
    tag_addr   = idx_q;
    tag_wdata  = '0;
    data_we    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;

    unique case (state_q)
      StIdle:    cpu_ready = 1'b1;
      StLookup:  tag_re = 1'b1;
      StCompare: ;
      StMem: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        // Line fetches are offset-aligned; write-throughs carry the full byte address.
        mem_addr = we_q ? addr_q : {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
      StFill: begin
        data_we = 1'b1;
        if (!we_q) begin
          tag_we    = 1'b1;
          tag_wdata = {1'b1, tag_q};
        end
      end
      StResp: begin
        cpu_done = 1'b1;
        cpu_hit  = hit_q;
      end
      StFlush: begin
        flush_busy = 1'b1;
        tag_we     = 1'b1;
        tag_addr   = flush_cnt_q;
      end
      default: ;
    endcase
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
